// File: rtl/rt_pkg.sv
// Shared types and constants for the multi-channel reaction timer.
//   state_e   : round controller states
//   status_e  : per-channel result codes (NONE/VALID/EARLY/TIMEOUT)
//   LFSR_TAPS : Galois tap mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   lfsr_next : one Galois LFSR step
package rt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_DELAY = 2'd1,
    ST_TIMING     = 2'd2,
    ST_DONE       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'd0,
    STAT_VALID   = 2'd1,
    STAT_EARLY   = 2'd2,
    STAT_TIMEOUT = 2'd3
  } status_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Shift right; feed the outgoing bit back into the tap positions.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick divider.
//   clk       : system clock
//   reset     : asynchronous, active-high
//   restart_i : synchronous restart, counter returns to 0 next clk
//   tick_c    : one-clk pulse every DIV clk (combinational from the counter)
module ms_tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_c = (cnt_q == CW'(DIV - 1));

  // Free-running modulo-DIV count, restartable from the controller.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || tick_c) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multi_reaction_timer.sv
// Multi-player reaction timer: after a random delay the go LED lights and each
// channel's stop press is timed in ms; reports per-channel results and winner.
//   clk, reset      : clock; asynchronous active-high reset
//   start           : round start button (asynchronous input)
//   stop[N_CH]      : per-channel stop buttons (asynchronous inputs)
//   clear           : synchronous return to IDLE, results zeroed
//   led             : go indicator
//   res_ms          : channel i time at [i*TW +: TW]
//   status          : channel i code at [2*i +: 2] (rt_pkg::status_e)
//   winner          : lowest index among the fastest VALID channels
//   winner_vld      : winner meaningful (DONE with at least one VALID)
//   done            : round finished
// Optional: define BEST_TIME_EN to add best_ms, the best VALID time seen since
// reset (all-ones until the first VALID round; unaffected by clear).
module multi_reaction_timer
  import rt_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned N_CH         = 2,
  parameter int unsigned TIMEOUT_MS   = 1000,
  parameter int unsigned DELAY_MIN_MS = 1000,
  parameter int unsigned DELAY_BITS   = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int unsigned TW = $clog2(TIMEOUT_MS + 1),
  localparam int unsigned WW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_CH-1:0]   stop,
  input  logic              clear,
  output logic              led,
  output logic [N_CH*TW-1:0] res_ms,
  output logic [2*N_CH-1:0] status,
  output logic [WW-1:0]     winner,
  output logic              winner_vld,
`ifdef BEST_TIME_EN
  output logic [TW-1:0]     best_ms,
`endif
  output logic              done
);

  localparam int unsigned DIV = CLK_HZ / 1000;
  localparam int unsigned DW  = $clog2(DELAY_MIN_MS + (1 << DELAY_BITS));
  localparam int unsigned NS  = N_CH + 1;

  // Button synchronisers and rising-edge detect; event lands 3 clk after input.
  logic [NS-1:0] sync1_q, sync2_q, sync3_q, ev_q;
  logic          ev_start;
  logic [N_CH-1:0] ev_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      ev_q    <= '0;
    end else begin
      sync1_q <= {stop, start};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      ev_q    <= sync2_q & ~sync3_q;
    end
  end

  assign ev_start = ev_q[0];
  assign ev_stop  = ev_q[NS-1:1];

  // Random delay source, free running.
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  // Controller state, counters, results and registered outputs.
  state_e          state_q, state_d;
  logic [DW-1:0]   dly_q, dly_d, dly_load;
  logic [TW-1:0]   ms_q, ms_d;
  status_e         stat_q [N_CH];
  status_e         stat_d [N_CH];
  logic [TW-1:0]   res_q  [N_CH];
  logic [TW-1:0]   res_d  [N_CH];
  logic            led_q, led_d, done_q, done_d, wvld_q, wvld_d;
  logic [WW-1:0]   win_q, win_d, win_idx;
  logic [TW-1:0]   win_t;
  logic            found, all_early, none_left;
  logic            tick, restart;

  assign dly_load = DW'(DELAY_MIN_MS) + DW'(lfsr_q[DELAY_BITS-1:0]);
  assign restart  = (state_d != state_q);

  ms_tick_gen #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .restart_i(restart),
    .tick_c   (tick)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    ms_d      = ms_q;
    stat_d    = stat_q;
    res_d     = res_q;
    all_early = 1'b0;
    none_left = 1'b0;
    found     = 1'b0;
    win_idx   = '0;
    win_t     = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ev_start) begin
          for (int i = 0; i < N_CH; i++) begin
            stat_d[i] = STAT_NONE;
            res_d[i]  = '0;
          end
          dly_d   = dly_load;
          ms_d    = '0;
          state_d = ST_WAIT_DELAY;
        end
      end

      ST_WAIT_DELAY: begin
        all_early = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          if (ev_stop[i] && stat_q[i] == STAT_NONE) begin
            stat_d[i] = STAT_EARLY;
            res_d[i]  = '0;
          end
          if (stat_d[i] != STAT_EARLY) all_early = 1'b0;
        end
        if (all_early) begin
          state_d = ST_DONE;
        end else if (tick) begin
          // A load of 0 or 1 both expire on the first tick.
          if (dly_q <= DW'(1)) begin
            dly_d   = '0;
            ms_d    = '0;
            state_d = ST_TIMING;
          end else begin
            dly_d = dly_q - DW'(1);
          end
        end
      end

      ST_TIMING: begin
        none_left = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          // Capture the pre-increment count, so a stop on the timeout tick wins.
          if (ev_stop[i] && stat_q[i] == STAT_NONE) begin
            stat_d[i] = STAT_VALID;
            res_d[i]  = ms_q;
          end
          if (stat_d[i] == STAT_NONE) none_left = 1'b0;
        end
        if (tick) ms_d = ms_q + TW'(1);
        if (none_left) begin
          state_d = ST_DONE;
        end else if (tick && ms_q == TW'(TIMEOUT_MS - 1)) begin
          for (int i = 0; i < N_CH; i++) begin
            if (stat_d[i] == STAT_NONE) begin
              stat_d[i] = STAT_TIMEOUT;
              res_d[i]  = TW'(TIMEOUT_MS);
            end
          end
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // clear overrides every event in the same cycle.
    if (clear) begin
      state_d = ST_IDLE;
      dly_d   = '0;
      ms_d    = '0;
      for (int i = 0; i < N_CH; i++) begin
        stat_d[i] = STAT_NONE;
        res_d[i]  = '0;
      end
    end

    // Fastest VALID channel; strict compare keeps the lowest index on ties.
    for (int i = 0; i < N_CH; i++) begin
      if (stat_d[i] == STAT_VALID && (!found || res_d[i] < win_t)) begin
        found   = 1'b1;
        win_t   = res_d[i];
        win_idx = WW'(i);
      end
    end

    led_d  = (state_d == ST_TIMING);
    done_d = (state_d == ST_DONE);
    wvld_d = done_d && found;
    win_d  = wvld_d ? win_idx : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      ms_q    <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
      wvld_q  <= 1'b0;
      win_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        stat_q[i] <= STAT_NONE;
        res_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      ms_q    <= ms_d;
      led_q   <= led_d;
      done_q  <= done_d;
      wvld_q  <= wvld_d;
      win_q   <= win_d;
      stat_q  <= stat_d;
      res_q   <= res_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign res_ms[g*TW +: TW] = res_q[g];
    assign status[2*g +: 2]   = stat_q[g];
  end

  assign led        = led_q;
  assign done       = done_q;
  assign winner     = win_q;
  assign winner_vld = wvld_q;

`ifdef BEST_TIME_EN
  // Running best over all rounds, folded in as DONE is entered.
  logic [TW-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (stat_d[i] == STAT_VALID && res_d[i] < best_d) best_d = res_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) best_q <= '1;
    else       best_q <= best_d;
  end

  assign best_ms = best_q;
`endif

endmodule

// File: doc/multi_reaction_timer.md
MULTI_REACTION_TIMER -- requirements
Module: multi_reaction_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning clk frequency in Hz; CLK_HZ/1000 SHALL be an integer >= 2.
REQ-002 SHALL have parameter N_CH, default 2, meaning number of player channels (1..8).
REQ-003 SHALL have parameter TIMEOUT_MS, default 1000, meaning reaction window in ms; TW = $clog2(TIMEOUT_MS+1).
REQ-004 SHALL have parameter DELAY_MIN_MS, default 1000, meaning minimum random delay.
REQ-005 SHALL have parameter DELAY_BITS, default 11, meaning random delay span: 0..2^DELAY_BITS-1 ms added to the minimum.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the nonzero LFSR reset value.
REQ-007 SHALL have port clk, input, 1, system clock.
REQ-008 SHALL have port reset, input, 1, reset; reset is asynchronous, active-high; clock is clk.
REQ-009 SHALL have port start, input, 1, round start button, asynchronous.
REQ-010 SHALL have port stop, input, N_CH, per-channel stop buttons, asynchronous.
REQ-011 SHALL have port clear, input, 1, synchronous return to IDLE.
REQ-012 SHALL have port led, output, 1, go indicator.
REQ-013 SHALL have port res_ms, output, N_CH*TW, per-channel captured time; channel i occupies bits [i*TW +: TW].
REQ-014 SHALL have port status, output, 2*N_CH, per-channel result: 0 NONE, 1 VALID, 2 EARLY, 3 TIMEOUT.
REQ-015 SHALL have port winner, output, max(1,$clog2(N_CH)), index of the fastest VALID channel.
REQ-016 SHALL have port winner_vld, output, 1, winner is meaningful.
REQ-017 SHALL have port done, output, 1, high in DONE.

Function
REQ-018 SHALL pass start and each stop bit through a 2-FF synchroniser and a rising-edge detector; the resulting one-cycle event occurs 3 clk after the input rises. All later timing is referenced to the event cycle.
REQ-019 SHALL generate a 1 ms tick, one clk wide, every CLK_HZ/1000 clk; the divider restarts at 0 on every state entry.
REQ-020 SHALL advance a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) every clk.
REQ-021 SHALL use the states IDLE, WAIT_DELAY, TIMING and DONE.
REQ-022 IDLE, start event: clear all status/res_ms, load delay counter = DELAY_MIN_MS + lfsr[DELAY_BITS-1:0], go to WAIT_DELAY.
REQ-023 WAIT_DELAY, tick: decrement the delay counter; when it reaches 0, go to TIMING with led=1 and ms counter=0.
REQ-024 WAIT_DELAY, stop event on a NONE channel: set that channel to EARLY, res_ms = 0; if every channel is EARLY, go to DONE.
REQ-025 TIMING, tick: increment the ms counter; stop event on a NONE channel: capture the ms counter before increment into res_ms and set VALID.
REQ-026 TIMING SHALL go to DONE when no channel is NONE, or when the ms counter reaches TIMEOUT_MS; at timeout, remaining NONE channels become TIMEOUT with res_ms = TIMEOUT_MS.
REQ-027 A stop and the timeout in the same cycle: the stop wins, the channel is VALID and res_ms = TIMEOUT_MS-1.
REQ-028 Simultaneous stops: each channel captures the same value; winner is the lowest index among the minimum VALID times.
REQ-029 Repeated stop on a non-NONE channel SHALL be ignored.
REQ-030 DONE: led=0, done=1, results held; a start event behaves as in IDLE.
REQ-031 A start event in WAIT_DELAY or TIMING SHALL be ignored.
REQ-032 clear, in any state: go to IDLE next clk, led=0, all results zeroed; clear SHALL take priority over every event in the same cycle.
REQ-033 winner_vld SHALL be 1 in DONE only when at least one channel is VALID; otherwise winner = 0.

Reset
REQ-034 On reset: state IDLE, led 0, res_ms 0, status 0, winner 0, winner_vld 0, done 0, LFSR = LFSR_SEED, synchronisers and counters 0.

Configuration
REQ-035 With BEST_TIME_EN defined, the block SHALL add output best_ms[TW-1:0], reset to all-ones, updated in DONE entry to the minimum of itself and every VALID res_ms; clear SHALL NOT affect it. Without BEST_TIME_EN, the port and its logic SHALL be absent.

Structure
REQ-036 Package rt_pkg SHALL hold the state enum, the status codes and the LFSR tap constant.
REQ-037 The tick divider SHALL be sub-module ms_tick_gen.

Verification (CLK_HZ=10000, N_CH=2, TIMEOUT_MS=20, DELAY_MIN_MS=5, DELAY_BITS=2)
REQ-038 start, then stop[0] at ms 7 of TIMING and stop[1] at ms 12 -> status 1/1, res_ms 7/12, winner 0, winner_vld 1.
REQ-039 stop[1] during WAIT_DELAY, then stop[0] at ms 4 -> status[1]=EARLY, status[0]=VALID with res 4, winner 0.
REQ-040 no stop -> DONE after 20 ms in TIMING; both channels TIMEOUT with res 20, winner_vld 0.
REQ-041 both stops in the same cycle at ms 9 -> both VALID with res 9, winner 0.
REQ-042 clear asserted mid-TIMING -> next clk IDLE, led 0, results 0; reset mid-WAIT_DELAY -> all outputs at their reset values.
REQ-043 both channels EARLY -> DONE before led rises, winner_vld 0.
